// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
// The bridge reuses the register offsets when decoding its device ranges.
package timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Modes 2'b1x fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Down-counting timer responder: CTRL/PRESET/COUNT register file, run-control FSM,
// combinational read mux and a registered interrupt line.
module timer_dev
    import timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0,
    parameter int          CNT_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]       ctrl_reg;
    logic [CNT_W-1:0] preset_reg;
    logic [CNT_W-1:0] count_reg;
    state_t           state_reg;
    logic             irq_flag_reg;
    logic             irq_reg;

    logic [1:0] reg_sel;
    logic       ctrl_wr;
    logic       preset_wr;
    logic       unused_bits;

    assign reg_sel     = Addr[3:2];
    assign ctrl_wr     = WE && (reg_sel == OFF_CTRL);
    assign preset_wr   = WE && (reg_sel == OFF_PRESET);
    assign unused_bits = ^{Addr[31:4], Addr[1:0], Din};

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg     <= 4'b0;
            preset_reg   <= PRESET_RST[CNT_W-1:0];
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            irq_flag_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            irq_reg <= irq_flag_reg & ctrl_reg[CTRL_IM];

            if (ctrl_wr)
                ctrl_reg <= Din[3:0];
            if (preset_wr)
                preset_reg <= Din[CNT_W-1:0];

            case (state_reg)
                ST_IDLE: begin
                    if (ctrl_reg[CTRL_EN])
                        state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= ST_CNT;
                end
                ST_CNT: begin
                    // Zero is caught here before any subtraction, so COUNT never wraps.
                    if (!ctrl_reg[CTRL_EN]) begin
                        state_reg <= ST_IDLE;
                    end else if (count_reg == '0) begin
                        state_reg    <= ST_INT;
                        irq_flag_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                ST_INT: begin
                    state_reg <= ST_IDLE;
                    if (is_reload(ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO]))
                        irq_flag_reg <= 1'b0;
                    else if (!ctrl_wr)
                        ctrl_reg[CTRL_EN] <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase

            // A CPU write to CTRL or PRESET acknowledges the interrupt and takes priority.
            if (ctrl_wr || preset_wr)
                irq_flag_reg <= 1'b0;
        end
    end

    always_comb begin
        Dout = 32'h0;
        case (reg_sel)
            OFF_CTRL:   Dout = {28'b0, ctrl_reg};
            OFF_PRESET: Dout = 32'(preset_reg);
            OFF_COUNT:  Dout = 32'(count_reg);
            default:    Dout = 32'h0;
        endcase
    end

    assign IRQ = irq_reg;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized bench for timer_dev; expectations come from the cycle-level timing rules
// (IRQ at k+4+N one-shot, period N+4 auto-reload) rather than from the FSM itself.
module tb_timer_dev;

    localparam logic [31:0] PRST     = 32'h0000_00A5;
    localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
    localparam logic [31:0] A_PRESET = 32'h0000_7f04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7f08;
    localparam logic [31:0] A_RSV    = 32'h0000_7f0c;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [31:0] Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    timer_dev #(.PRESET_RST(PRST), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    // Reference model: value/level observed just after edge k+m for a run started by a CTRL write at edge k.
    function automatic logic [31:0] os_count(input int n, input int m);
        return (m - 2 >= n) ? 32'd0 : 32'(n - (m - 2));
    endfunction

    function automatic logic os_irq(input int n, input int m);
        return (m >= n + 4);
    endfunction

    function automatic logic ar_irq(input int n, input int m);
        return (m >= n + 4) && (((m - n - 4) % (n + 4)) == 0);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = Dout;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        WE    = 1'b1;
        Addr  = A_CTRL;
        Din   = 32'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        WE    = 1'b0;
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq: got %0b expected 0", IRQ); end
        rd(A_CTRL, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %0h expected 0", v); end
        rd(A_PRESET, v);
        total++;
        if (v !== PRST) begin bad++; $display("FAIL reset_preset: got %0h expected %0h", v, PRST); end
        rd(A_COUNT, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_count: got %0h expected 0", v); end
        $display("reset: ctrl/preset/count checked");
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        int n;
        for (int run = 0; run < 2; run++) begin
            n = (run == 0) ? 5 : int'($urandom_range(1, 12));
            wr(A_PRESET, 32'(n));
            wr(A_CTRL, 32'h9);
            for (int m = 1; m <= n + 7; m++) begin
                tick(1);
                if (m >= 2) begin
                    rd(A_COUNT, v);
                    total++;
                    if (v !== os_count(n, m)) begin
                        bad++;
                        $display("FAIL oneshot_count n=%0d m=%0d: got %0d expected %0d", n, m, v, os_count(n, m));
                    end
                end
                total++;
                if (IRQ !== os_irq(n, m)) begin
                    bad++;
                    $display("FAIL oneshot_irq n=%0d m=%0d: got %0b expected %0b", n, m, IRQ, os_irq(n, m));
                end
            end
            rd(A_CTRL, v);
            total++;
            if (v !== 32'h8) begin bad++; $display("FAIL oneshot_en_clear: got %0h expected 8", v); end
            wr(A_CTRL, 32'h0);
            total++;
            if (IRQ !== 1'b1) begin bad++; $display("FAIL oneshot_irq_hold: got %0b expected 1", IRQ); end
            tick(1);
            total++;
            if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_irq_ack: got %0b expected 0", IRQ); end
            $display("oneshot: preset=%0d run checked", n);
        end
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        int n;
        int pulses;
        for (int run = 0; run < 2; run++) begin
            n = (run == 0) ? 3 : int'($urandom_range(1, 8));
            pulses = 0;
            tick(3);
            wr(A_PRESET, 32'(n));
            wr(A_CTRL, 32'hB);
            for (int m = 1; m <= 3 * (n + 4) + 1; m++) begin
                tick(1);
                if (IRQ === 1'b1)
                    pulses++;
                total++;
                if (IRQ !== ar_irq(n, m)) begin
                    bad++;
                    $display("FAIL reload_irq n=%0d m=%0d: got %0b expected %0b", n, m, IRQ, ar_irq(n, m));
                end
            end
            total++;
            if (pulses != 3) begin bad++; $display("FAIL reload_pulses n=%0d: got %0d expected 3", n, pulses); end
            rd(A_CTRL, v);
            total++;
            if (v !== 32'hB) begin bad++; $display("FAIL reload_ctrl: got %0h expected b", v); end
            wr(A_CTRL, 32'h0);
            tick(1);
            total++;
            if (IRQ !== 1'b0) begin bad++; $display("FAIL reload_stop_irq: got %0b expected 0", IRQ); end
            $display("autoreload: preset=%0d pulses=%0d", n, pulses);
        end
    endtask

    task automatic test_pause;
        logic [31:0] v;
        int p;
        p = int'($urandom_range(8, 20));
        tick(3);
        wr(A_PRESET, 32'(p));
        wr(A_CTRL, 32'h9);
        tick(p - 5);
        rd(A_COUNT, v);
        total++;
        if (v !== 32'd7) begin bad++; $display("FAIL pause_pre: got %0d expected 7", v); end
        wr(A_CTRL, 32'h8);
        rd(A_COUNT, v);
        total++;
        if (v !== 32'd6) begin bad++; $display("FAIL pause_at: got %0d expected 6", v); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            rd(A_COUNT, v);
            total++;
            if (v !== 32'd6) begin bad++; $display("FAIL pause_hold i=%0d: got %0d expected 6", i, v); end
            total++;
            if (IRQ !== 1'b0) begin bad++; $display("FAIL pause_irq i=%0d: got %0b expected 0", i, IRQ); end
        end
        wr(A_CTRL, 32'h9);
        tick(1);
        rd(A_COUNT, v);
        total++;
        if (v !== 32'd6) begin bad++; $display("FAIL pause_load_wait: got %0d expected 6", v); end
        tick(1);
        rd(A_COUNT, v);
        total++;
        if (v !== 32'(p)) begin bad++; $display("FAIL pause_reload: got %0d expected %0d", v, p); end
        wr(A_CTRL, 32'h0);
        $display("pause: preset=%0d held at 6 then reloaded", p);
    endtask

    task automatic test_edges;
        logic [31:0] v;
        logic [31:0] pv;
        int n;
        tick(3);
        wr(A_PRESET, 32'h0);
        wr(A_CTRL, 32'h9);
        for (int m = 1; m <= 5; m++) begin
            tick(1);
            total++;
            if (IRQ !== (m >= 4)) begin bad++; $display("FAIL zero_preset_irq m=%0d: got %0b expected %0b", m, IRQ, (m >= 4)); end
        end
        wr(A_CTRL, 32'h0);
        tick(1);
        $display("edges: preset=0 one-shot checked");

        n = int'($urandom_range(1, 5));
        wr(A_PRESET, 32'(n));
        wr(A_CTRL, 32'h1);
        for (int m = 1; m <= n + 8; m++) begin
            tick(1);
            total++;
            if (IRQ !== 1'b0) begin bad++; $display("FAIL im0_irq m=%0d: got %0b expected 0", m, IRQ); end
        end
        rd(A_CTRL, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL im0_en_clear: got %0h expected 0", v); end
        $display("edges: IM=0 run preset=%0d checked", n);

        wr(A_COUNT, 32'hFF);
        rd(A_COUNT, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL count_ro: got %0h expected 0", v); end
        pv = $urandom;
        wr(A_PRESET, pv);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reserved_read: got %0h expected 0", v); end
        rd(A_PRESET, v);
        total++;
        if (v !== pv) begin bad++; $display("FAIL preset_readback: got %0h expected %0h", v, pv); end
        rd(A_CTRL, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reserved_no_ctrl: got %0h expected 0", v); end
        $display("edges: COUNT write ignored, reserved reads 0");
    endtask

    task automatic test_collision;
        logic [31:0] v;
        int n;
        n = int'($urandom_range(1, 6));
        tick(2);
        wr(A_PRESET, 32'(n));
        wr(A_CTRL, 32'h9);
        tick(n + 3);
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL coll_pre_irq: got %0b expected 0", IRQ); end
        wr(A_CTRL, 32'h9);
        rd(A_CTRL, v);
        total++;
        if (v !== 32'h9) begin bad++; $display("FAIL coll_ctrl: got %0h expected 9", v); end
        total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL coll_irq_pulse: got %0b expected 1", IRQ); end
        tick(1);
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL coll_flag_clear: got %0b expected 0", IRQ); end
        for (int m = 2; m <= n + 4; m++) begin
            tick(1);
            if (m == 2) begin
                rd(A_COUNT, v);
                total++;
                if (v !== 32'(n)) begin bad++; $display("FAIL coll_reload: got %0d expected %0d", v, n); end
            end
            total++;
            if (IRQ !== os_irq(n, m)) begin bad++; $display("FAIL coll_rerun_irq m=%0d: got %0b expected %0b", m, IRQ, os_irq(n, m)); end
        end
        wr(A_CTRL, 32'h0);
        $display("collision: preset=%0d CPU write won, new run checked", n);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        tick(2);
        wr(A_PRESET, 32'd50);
        wr(A_CTRL, 32'h9);
        tick(10);
        @(negedge clk);
        reset = 1'b1;
        WE    = 1'b1;
        Addr  = A_PRESET;
        Din   = 32'h1234;
        @(posedge clk);
        #1;
        reset = 1'b0;
        WE    = 1'b0;
        rd(A_CTRL, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL midreset_ctrl: got %0h expected 0", v); end
        rd(A_PRESET, v);
        total++;
        if (v !== PRST) begin bad++; $display("FAIL midreset_preset: got %0h expected %0h", v, PRST); end
        tick(3);
        rd(A_COUNT, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL midreset_count: got %0h expected 0", v); end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %0b expected 0", IRQ); end
        $display("reset_mid: state cleared during a run");
    endtask

    initial begin
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = 32'h0;
        Din   = 32'h0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_edges();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
